mem_port_arbiter: RTL and testbench

- Shares one single-ported SRAM_wrapper instance between the CPU instruction-fetch port (IM) and data port (DM), so a unified memory replaces the split IM1/DM1 arrangement.
- Round-robin arbitration; at most one grant per cycle; pipelined so a grant can issue every cycle.
- Read data returns one cycle after grant, matching the 1-cycle SRAM read latency, and is tagged back to the owning port.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between the instruction (IM) and data (DM)
// ports; read data returns one cycle after grant and is tagged back to the owning port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              im_req,
  input  logic [31:0]       im_addr,
  output logic              im_ready,
  output logic              im_rvalid,
  output logic [DATA_W-1:0] im_rdata,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_bweb,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              sram_ceb,
  output logic              sram_web,
  output logic [DATA_W-1:0] sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  localparam logic PortIm = 1'b0;
  localparam logic PortDm = 1'b1;

  logic              r_rr_last;
  logic              r_pend_valid;
  logic              r_pend_port;
  logic [DATA_W-1:0] r_im_hold;
  logic [DATA_W-1:0] r_dm_hold;

  logic              w_gnt_im;
  logic              w_gnt_dm;
  logic              w_rd_gnt;
  logic              w_unused;

  // Byte offset and bits above the SRAM word range do not select anything.
  assign w_unused = ^{im_addr[31:ADDR_W+2], im_addr[1:0], dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  // Grants are held off while reset is asserted so nothing is accepted during reset.
  always_comb begin
    w_gnt_im = 1'b0;
    w_gnt_dm = 1'b0;
    if (rst) begin
      if (im_req && dm_req) begin
        if (r_rr_last == PortDm) begin
          w_gnt_im = 1'b1;
        end else begin
          w_gnt_dm = 1'b1;
        end
      end else begin
        w_gnt_im = im_req;
        w_gnt_dm = dm_req;
      end
    end
  end

  assign im_ready = w_gnt_im;
  assign dm_ready = w_gnt_dm;
  assign w_rd_gnt = w_gnt_im | (w_gnt_dm & ~dm_we);

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (w_gnt_im) begin
      sram_ceb = 1'b0;
      sram_a   = im_addr[ADDR_W+1:2];
    end else if (w_gnt_dm) begin
      sram_ceb = 1'b0;
      sram_a   = dm_addr[ADDR_W+1:2];
      if (dm_we) begin
        sram_web  = 1'b0;
        sram_bweb = dm_bweb;
        sram_di   = dm_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_last <= PortDm;
    end else if (w_gnt_im) begin
      r_rr_last <= PortIm;
    end else if (w_gnt_dm) begin
      r_rr_last <= PortDm;
    end
  end

  // Read tag: one cycle after a read grant the owner sees rvalid with the SRAM output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_port  <= PortIm;
    end else begin
      r_pend_valid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_pend_port <= w_gnt_dm ? PortDm : PortIm;
      end
    end
  end

  assign im_rvalid = r_pend_valid && (r_pend_port == PortIm);
  assign dm_rvalid = r_pend_valid && (r_pend_port == PortDm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im_hold <= '0;
      r_dm_hold <= '0;
    end else begin
      if (im_rvalid) begin
        r_im_hold <= sram_do;
      end
      if (dm_rvalid) begin
        r_dm_hold <= sram_do;
      end
    end
  end

  // Hold registers keep rdata stable until that port's next read returns.
  assign im_rdata = im_rvalid ? sram_do : r_im_hold;
  assign dm_rdata = dm_rvalid ? sram_do : r_dm_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural 1-cycle SRAM, per-port expected-read queues
// filled at grant time and drained by an independent rvalid monitor.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          im_req;
  logic [31:0]   im_addr;
  logic          im_ready;
  logic          im_rvalid;
  logic [DW-1:0] im_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_bweb;
  logic          dm_ready;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          sram_ceb;
  logic          sram_web;
  logic [DW-1:0] sram_bweb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] im_q[$];
  logic [31:0] dm_q[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_bweb(dm_bweb), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  // Single-ported SRAM, bit-masked writes (bweb=0 writes), 1-cycle read latency.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
      else sram_do <= mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops the owning port's queue.
  always @(negedge clk) begin
    if (im_rvalid === 1'b1) begin
      if (im_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL im_rvalid_spurious: got rvalid=1 required 0");
      end else chk("im_rdata", im_rdata, im_q.pop_front());
    end
    if (dm_rvalid === 1'b1) begin
      if (dm_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dm_rvalid_spurious: got rvalid=1 required 0");
      end else chk("dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] dbw,
                      input bit e_im, input bit e_dm, input logic [31:0] e_data,
                      input bit hold_chk);
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    im_req = ir; im_addr = ia;
    dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_bweb = dbw;
    @(negedge clk);
    chk("im_ready", {31'd0, im_ready}, {31'd0, e_im});
    chk("dm_ready", {31'd0, dm_ready}, {31'd0, e_dm});
    ea = e_im ? ia[AW+1:2] : (e_dm ? da[AW+1:2] : '0);
    chk("sram_ceb", {31'd0, sram_ceb}, {31'd0, !(e_im || e_dm)});
    chk("sram_a", {18'd0, sram_a}, {18'd0, ea});
    chk("sram_web", {31'd0, sram_web}, {31'd0, !(e_dm && dwe)});
    if (e_dm && dwe) begin
      chk("sram_bweb", sram_bweb, dbw);
      chk("sram_di", sram_di, dwd);
    end
    if (e_im) im_q.push_back(e_data);
    else if (e_dm && !dwe) dm_q.push_back(e_data);
    if (hold_chk) begin
      chk("im_hold_rvalid", {31'd0, im_rvalid}, 32'd0);
      chk("im_hold_rdata", im_rdata, 32'h13);
    end
  endtask

  task automatic idle(input bit hold_chk);
    step(0, 0, 0, 0, 0, 0, '1, 0, 0, 0, hold_chk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    im_req = 1'b0; dm_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[3] = 32'h13;

    // Requests during reset must not be granted; SRAM idle; outputs cleared.
    rst = 1'b0;
    im_req = 1'b1; im_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h5555_5555; dm_bweb = '0;
    #12;
    chk("rst_im_ready", {31'd0, im_ready}, 32'd0);
    chk("rst_dm_ready", {31'd0, dm_ready}, 32'd0);
    chk("rst_sram_ceb", {31'd0, sram_ceb}, 32'd1);
    chk("rst_sram_web", {31'd0, sram_web}, 32'd1);
    chk("rst_sram_a", {18'd0, sram_a}, 32'd0);
    chk("rst_sram_bweb", sram_bweb, 32'hFFFF_FFFF);
    chk("rst_sram_di", sram_di, 32'd0);
    chk("rst_im_rvalid", {31'd0, im_rvalid}, 32'd0);
    chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("rst_im_rdata", im_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    im_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // IM-only back-to-back reads.
    step(1, 32'h0, 0, 0, 0, 0, '1, 1, 0, 32'h1000_0000, 0);
    step(1, 32'h4, 0, 0, 0, 0, '1, 1, 0, 32'h1000_0001, 0);
    step(1, 32'h8, 0, 0, 0, 0, '1, 1, 0, 32'h1000_0002, 0);
    // DM full write, read-after-write, byte write, read.
    step(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h100, 0, '1, 0, 1, 32'hDEAD_BEEF, 0);
    step(0, 0, 1, 1, 32'h100, 32'h0000_00AA, 32'hFFFF_FF00, 0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h100, 0, '1, 0, 1, 32'hDEAD_BEAA, 0);
    // IM read of 0x13, then DM traffic while IM rdata must hold.
    step(1, 32'hC, 0, 0, 0, 0, '1, 1, 0, 32'h13, 0);
    step(0, 0, 1, 0, 32'h100, 0, '1, 0, 1, 32'hDEAD_BEAA, 0);
    step(0, 0, 1, 0, 32'h103, 0, '1, 0, 1, 32'hDEAD_BEAA, 1);
    step(0, 0, 1, 0, 32'h100, 0, '1, 0, 1, 32'hDEAD_BEAA, 1);
    idle(1);

    // Continuous conflict from reset: IM first, then alternating.
    do_reset();
    step(1, 32'h0, 1, 0, 32'h10, 0, '1, 1, 0, 32'h1000_0000, 0);
    step(1, 32'h4, 1, 0, 32'h10, 0, '1, 0, 1, 32'h1000_0004, 0);
    step(1, 32'h4, 1, 0, 32'h14, 0, '1, 1, 0, 32'h1000_0001, 0);
    step(1, 32'h8, 1, 0, 32'h14, 0, '1, 0, 1, 32'h1000_0005, 0);
    step(1, 32'h8, 1, 0, 32'h18, 0, '1, 1, 0, 32'h1000_0002, 0);
    step(1, 32'hC, 1, 0, 32'h18, 0, '1, 0, 1, 32'h1000_0006, 0);
    step(1, 32'hC, 0, 0, 0, 0, '1, 1, 0, 32'h13, 0);
    idle(0);
    idle(0);

    // Reset right after a DM read grant: the read is discarded.
    step(0, 0, 1, 0, 32'h10, 0, '1, 0, 1, 32'h1000_0004, 0);
    void'(dm_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk("inflight_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("inflight_dm_rdata", dm_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 32'h4, 1, 0, 32'h14, 0, '1, 1, 0, 32'h1000_0001, 0);
    step(0, 0, 1, 0, 32'h14, 0, '1, 0, 1, 32'h1000_0005, 0);
    idle(0);
    idle(0);

    chk("im_q_drained", im_q.size(), 32'd0);
    chk("dm_q_drained", dm_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
